// File: rtl/csa_nibble_sequencer_if.sv
// Operand/result handshake and adder-stage bus for csa_nibble_sequencer.
// Optional feature macro: CSA_SEQ_SUB_EN adds the in_sub operand flag.
interface csa_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  // Operand handshake
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef CSA_SEQ_SUB_EN
  logic             in_sub;
`endif

  // Nibble adder stage (purely combinational outside this block)
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  // Result handshake
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  // Upstream producer / adder / downstream consumer side
  modport master (
`ifdef CSA_SEQ_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout,
    input  out_valid, out_sum, out_cout,
    output out_ready
  );

  // Sequencer side
  modport slave (
`ifdef CSA_SEQ_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout,
    output out_valid, out_sum, out_cout,
    input  out_ready
  );
endinterface

// File: rtl/csa_nibble_sequencer.sv
// Nibble-serial operand sequencer around a 4-bit carry-select adder stage.
// Feeds one nibble per cycle LSB first, chains carry through a register and
// presents the WIDTH-bit sum plus final carry on a valid/ready output.
// Optional feature macro: CSA_SEQ_SUB_EN (A-B via inverted B and carry-in 1).
module csa_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  csa_nibble_sequencer_if.slave bus
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Reject widths that cannot be split into whole nibbles
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("csa_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_nx;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       add_a_q, add_a_d;
  logic [3:0]       add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;

  // Effective B operand and carry-in as captured on the in handshake
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CSA_SEQ_SUB_EN
  assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;
`else
  assign b_eff   = bus.in_b;
  assign cin_eff = bus.in_cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)          state_d = RUN;
      RUN:     if (idx_q == LAST_IDX)     state_d = DONE;
      DONE:    if (bus.out_ready)         state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Output and datapath next values; adder nibbles are set up one cycle ahead
  // so the add_* outputs come straight from flops
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    add_a_d     = 4'h0;
    add_b_d     = 4'h0;
    add_cin_d   = 1'b0;
    idx_nx      = idx_q + IDX_W'(1);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a;
          b_d        = b_eff;
          carry_d    = cin_eff;
          idx_d      = '0;
          in_ready_d = 1'b0;
          add_a_d    = bus.in_a[3:0];
          add_b_d    = b_eff[3:0];
          add_cin_d  = cin_eff;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = bus.add_s;
        carry_d = bus.add_cout;
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
        end else begin
          idx_d     = idx_nx;
          add_a_d   = 4'(a_q >> {idx_nx, 2'b00});
          add_b_d   = 4'(b_q >> {idx_nx, 2'b00});
          add_cin_d = bus.add_cout;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_a_q     <= 4'h0;
      add_b_q     <= 4'h0;
      add_cin_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;

endmodule
